pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and stall sequencer for the five-stage RV32 pipeline. It watches the decode-stage source registers, the execute-stage load destination, branch resolution in execute, and the data-memory handshake. From these it drives the per-stage register enables, the ID/EX bubble insert and the IF/ID flush. It also keeps stall and flush performance counters and a sticky memory-timeout error.

## Interface
Parameters:
- LOAD_USE_CYCLES, 1: bubbles inserted per load-use hazard (1..15).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before `mem_err` sets (1..65535).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID (instr[19:15], instr[24:20])
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source
- ex_rd  in  5  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load (`mem_rd` of ID/EX)
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_req  in  1  MEM stage issues a data-memory access this cycle
- mem_ready  in  1  data memory completes the access this cycle
- perf_clr  in  1  synchronous clear of both perf counters
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  stage register enables
- id_ex_bubble  out  1  load zeros into ID/EX control (`write_back`, `mem_wr`, `mem_rd`)
- if_id_flush  out  1  replace the IF/ID instruction with NOP
- stall_cycles  out  32  saturating count of cycles with `pc_en`=0
- flush_count  out  32  saturating count of taken-branch flushes
- mem_err  out  1  sticky, set on memory timeout
- state_o  out  2  current FSM state (debug)

## Operation
- Load-use hazard `lu` = `ex_is_load` && `ex_rd`!=0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
- Memory stall `ms` = `mem_req` && !`mem_ready`.
- FSM states (2-bit encoding):
  - RUN=0
  - STALL=1
  - MEM_WAIT=2
- RUN. Evaluate in priority order:
  - `ms`: all four enables=0, bubble=0, flush=0. Save return state = RUN. Next state MEM_WAIT.
  - `ex_branch_taken`: all enables=1, `if_id_flush`=1, `id_ex_bubble`=1. Stay in RUN. `flush_count`++.
  - `lu`: `pc_en`=`if_id_en`=0, `id_ex_en`=`ex_mem_en`=1, `id_ex_bubble`=1. If LOAD_USE_CYCLES>1, load cnt=LOAD_USE_CYCLES-1 and go to STALL.
  - Otherwise: all enables=1, bubble=0, flush=0.
- STALL. Outputs are the same as the RUN `lu` case.
  - cnt decrements each cycle. When cnt==1, next state is RUN.
  - `ms` has priority: freeze as above, save return state = STALL, and hold cnt.
  - `ex_branch_taken` is ignored in STALL, because EX holds a bubble.
- MEM_WAIT. All enables=0, bubble=0, flush=0.
  - The wait counter increments each cycle and saturates at MEM_TIMEOUT.
  - When it reaches MEM_TIMEOUT, `mem_err` sets. `mem_err` stays set until reset, and the FSM keeps waiting.
  - On `mem_ready`: this cycle's outputs are still frozen, the wait counter clears, and the next state is the saved return state.
- Perf counters:
  - Each counter saturates at 0xFFFF_FFFF.
  - `perf_clr` takes precedence over increment in the same cycle.

## Timing
- All enable, bubble and flush outputs are combinational from state plus inputs. Zero-cycle response is required because the hazard must block the same edge.
- Registered elements:
  - state
  - cnt (4b)
  - return state
  - wait counter (16b)
  - perf counters
  - `mem_err`
- Reset (asynchronous, while `rst_n`=0):
  - state=RUN, cnt=0, wait counter=0, counters=0, `mem_err`=0.
  - All enables, `id_ex_bubble` and `if_id_flush` are forced to 0 regardless of inputs.
- Reset asserted mid-STALL or mid-MEM_WAIT aborts immediately. There is no pending state after release.
- A load-use hazard costs exactly LOAD_USE_CYCLES cycles with `pc_en`=0.
- A taken branch costs 0 stall cycles and one flushed slot in IF/ID and one in ID/EX.
- `stall_cycles` updates on the edge ending the counted cycle, so it is visible the next cycle.

## Structure
- Shared package `pipe_pkg`: `pc_state_e` enum {RUN, STALL, MEM_WAIT}, `REG_ZERO`=5'd0, and the perf counter width constant.
- Sub-module `sat_counter` (parameter WIDTH; ports clr, inc, q), instantiated for both perf counters.
- Hazard compare and the FSM stay inline.

## Test plan
- Load `x5` in EX, ID reads `rs1`=5, LOAD_USE_CYCLES=1 -> one cycle with `pc_en`=0 and `id_ex_bubble`=1, then RUN; `stall_cycles`=1.
- Same hazard with LOAD_USE_CYCLES=3 -> `state_o`=1 for 2 cycles, exactly 3 cycles with `pc_en`=0; `ex_rd`=0 with matching `rs` -> no stall.
- `ex_branch_taken` and `lu` in the same cycle -> `if_id_flush`=1, `id_ex_bubble`=1, `pc_en`=1; `flush_count`=1; FSM stays RUN.
- In STALL with cnt=2, hold `ms` for 4 cycles -> all enables 0; on `mem_ready` return to STALL with cnt=2 and finish the remaining stall.
- MEM_TIMEOUT=5, hold `mem_ready`=0 -> `mem_err`=1 after 5 MEM_WAIT cycles; remains 1 after `mem_ready` until `rst_n` low.
- Drop `rst_n` asynchronously mid-MEM_WAIT -> all outputs 0 before the next `clk` edge; after release, `state_o`=0 and counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline hazard/stall sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } pc_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         PERF_W   = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; synchronous clear wins over increment, holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer: stage enables, bubble and flush are combinational from state and inputs.
// Memory stalls freeze every stage; load-use hazards hold PC and IF/ID while EX drains a bubble.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              perf_clr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count,
  output logic              mem_err,
  output logic [1:0]        state_o
);

  localparam logic [3:0]  LU_RELOAD = 4'(LOAD_USE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT   = 16'(MEM_TIMEOUT);

  logic        lu, ms;
  pc_state_e   state_q, state_d, ret_q, ret_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wait_q, wait_d;
  logic        en_pc, en_ifid, en_idex, en_exmem, bubble, flush, flush_inc;

  assign lu = ex_is_load && (ex_rd != REG_ZERO) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign ms = mem_req && !mem_ready;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    en_pc     = 1'b1;
    en_ifid   = 1'b1;
    en_idex   = 1'b1;
    en_exmem  = 1'b1;
    bubble    = 1'b0;
    flush     = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (ms) begin
          {en_pc, en_ifid, en_idex, en_exmem} = 4'b0000;
          ret_d   = RUN;
          state_d = MEM_WAIT;
        end else if (ex_branch_taken) begin
          flush     = 1'b1;
          bubble    = 1'b1;
          flush_inc = 1'b1;
        end else if (lu) begin
          en_pc   = 1'b0;
          en_ifid = 1'b0;
          bubble  = 1'b1;
          if (LOAD_USE_CYCLES > 1) begin
            cnt_d   = LU_RELOAD;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        // EX already holds a bubble here, so a taken branch cannot occur.
        if (ms) begin
          {en_pc, en_ifid, en_idex, en_exmem} = 4'b0000;
          ret_d   = STALL;
          state_d = MEM_WAIT;
        end else begin
          en_pc   = 1'b0;
          en_ifid = 1'b0;
          bubble  = 1'b1;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        {en_pc, en_ifid, en_idex, en_exmem} = 4'b0000;
        if (mem_ready) begin
          wait_d  = '0;
          state_d = ret_q;
        end else if (wait_q != TIMEOUT) begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      wait_q  <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      if (wait_d == TIMEOUT) mem_err <= 1'b1;
    end
  end

  // Reset must silence the pipeline even while inputs are still active.
  assign pc_en        = rst_n & en_pc;
  assign if_id_en     = rst_n & en_ifid;
  assign id_ex_en     = rst_n & en_idex;
  assign ex_mem_en    = rst_n & en_exmem;
  assign id_ex_bubble = rst_n & bubble;
  assign if_id_flush  = rst_n & flush;
  assign state_o      = state_q;

  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (!en_pc),
    .q     (stall_cycles)
  );

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (flush_inc),
    .q     (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench: s_ instance has LOAD_USE_CYCLES=3/MEM_TIMEOUT=5, f_ instance LOAD_USE_CYCLES=1/MEM_TIMEOUT=255.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
  logic       mem_req, mem_ready, perf_clr;

  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_bubble, s_flush, s_mem_err;
  logic [31:0] s_stall, s_flushes;
  logic [1:0]  s_state;
  logic        f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_bubble, f_flush, f_mem_err;
  logic [31:0] f_stall, f_flushes;
  logic [1:0]  f_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.LOAD_USE_CYCLES(3), .MEM_TIMEOUT(5)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
    .id_ex_bubble(s_bubble), .if_id_flush(s_flush), .stall_cycles(s_stall),
    .flush_count(s_flushes), .mem_err(s_mem_err), .state_o(s_state)
  );

  pipeline_ctrl #(.LOAD_USE_CYCLES(1), .MEM_TIMEOUT(255)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_en(f_pc_en), .if_id_en(f_if_id_en), .id_ex_en(f_id_ex_en), .ex_mem_en(f_ex_mem_en),
    .id_ex_bubble(f_bubble), .if_id_flush(f_flush), .stall_cycles(f_stall),
    .flush_count(f_flushes), .mem_err(f_mem_err), .state_o(f_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic load_use_rs1(input logic [4:0] r);
    ex_is_load = 1'b1; ex_rd = r; id_rs1 = r; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    load_use_rs1(5'd5);
    ex_branch_taken = 1'b1;
    #2;
    check("rst_pc_en", {31'd0, s_pc_en}, 32'd0);
    check("rst_flush", {31'd0, s_flush}, 32'd0);
    check("rst_state", {30'd0, s_state}, 32'd0);
    check("rst_stall", s_stall, 32'd0);
    idle();
    #10 rst_n = 1'b1;
    cyc();
    #2;
    check("idle_pc_en", {31'd0, s_pc_en}, 32'd1);
    check("idle_ex_mem_en", {31'd0, f_ex_mem_en}, 32'd1);

    // Load x5 in EX, ID reads rs1=x5.
    load_use_rs1(5'd5);
    #2;
    check("lu_f_pc_en", {31'd0, f_pc_en}, 32'd0);
    check("lu_f_if_id_en", {31'd0, f_if_id_en}, 32'd0);
    check("lu_f_id_ex_en", {31'd0, f_id_ex_en}, 32'd1);
    check("lu_f_bubble", {31'd0, f_bubble}, 32'd1);
    check("lu_f_flush", {31'd0, f_flush}, 32'd0);
    check("lu_s_pc_en", {31'd0, s_pc_en}, 32'd0);
    cyc();
    idle();
    #2;
    check("lu_f_back_run", {31'd0, f_pc_en}, 32'd1);
    check("lu_f_stall_cnt", f_stall, 32'd1);
    check("lu_s_state1", {30'd0, s_state}, 32'd1);
    check("lu_s_pc_en1", {31'd0, s_pc_en}, 32'd0);
    cyc();
    #2;
    check("lu_s_state2", {30'd0, s_state}, 32'd1);
    check("lu_s_bubble2", {31'd0, s_bubble}, 32'd1);
    cyc();
    #2;
    check("lu_s_state_run", {30'd0, s_state}, 32'd0);
    check("lu_s_pc_en_run", {31'd0, s_pc_en}, 32'd1);
    check("lu_s_stall_cnt", s_stall, 32'd3);

    // No hazard: destination x0, or source not actually read.
    load_use_rs1(5'd0);
    #2;
    check("x0_no_stall", {31'd0, s_pc_en}, 32'd1);
    load_use_rs1(5'd9);
    id_uses_rs1 = 1'b0;
    #2;
    check("unused_rs1_no_stall", {31'd0, s_pc_en}, 32'd1);
    idle();
    cyc();

    // Taken branch together with a load-use hazard: branch wins.
    load_use_rs1(5'd5);
    ex_branch_taken = 1'b1;
    #2;
    check("br_flush", {31'd0, f_flush}, 32'd1);
    check("br_bubble", {31'd0, f_bubble}, 32'd1);
    check("br_pc_en", {31'd0, s_pc_en}, 32'd1);
    check("br_if_id_en", {31'd0, s_if_id_en}, 32'd1);
    cyc();
    idle();
    #2;
    check("br_flush_count", f_flushes, 32'd1);
    check("br_s_flush_count", s_flushes, 32'd1);
    check("br_state_run", {30'd0, s_state}, 32'd0);
    check("br_no_stall", s_stall, 32'd3);

    // rs2 hazard with perf_clr in the same cycle: clear beats increment.
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    id_rs1 = 5'd3; id_uses_rs1 = 1'b1; perf_clr = 1'b1;
    #2;
    check("rs2_pc_en", {31'd0, f_pc_en}, 32'd0);
    cyc();
    idle();
    #2;
    check("clr_f_stall", f_stall, 32'd0);
    check("clr_f_flush", f_flushes, 32'd0);
    check("clr_s_stall", s_stall, 32'd0);
    cyc();
    cyc();
    #2;
    check("clr_s_state", {30'd0, s_state}, 32'd0);
    check("clr_s_stall_after", s_stall, 32'd2);

    // Memory stall arriving in STALL with cnt=2, held 4 cycles.
    load_use_rs1(5'd5);
    cyc();
    idle();
    mem_req = 1'b1;
    #2;
    check("ms_stall_state", {30'd0, s_state}, 32'd1);
    check("ms_stall_id_ex_en", {31'd0, s_id_ex_en}, 32'd0);
    check("ms_stall_ex_mem_en", {31'd0, s_ex_mem_en}, 32'd0);
    check("ms_stall_bubble", {31'd0, s_bubble}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #2;
      check("ms_wait_state", {30'd0, s_state}, 32'd2);
      check("ms_wait_pc_en", {31'd0, s_pc_en}, 32'd0);
    end
    cyc();
    mem_ready = 1'b1;
    #2;
    check("ms_ready_frozen", {31'd0, s_id_ex_en}, 32'd0);
    cyc();
    idle();
    #2;
    check("ms_ret_state", {30'd0, s_state}, 32'd1);
    check("ms_ret_bubble", {31'd0, s_bubble}, 32'd1);
    check("ms_f_ret_run", {30'd0, f_state}, 32'd0);
    cyc();
    #2;
    check("ms_ret_cnt1", {30'd0, s_state}, 32'd1);
    cyc();
    #2;
    check("ms_done_state", {30'd0, s_state}, 32'd0);
    check("ms_stall_total", s_stall, 32'd10);
    check("ms_no_err", {31'd0, s_mem_err}, 32'd0);

    // Memory timeout: 5 MEM_WAIT cycles set the sticky error.
    mem_req = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) cyc();
    #2;
    check("to_before", {31'd0, s_mem_err}, 32'd0);
    cyc();
    #2;
    check("to_set", {31'd0, s_mem_err}, 32'd1);
    cyc();
    cyc();
    mem_ready = 1'b1;
    cyc();
    idle();
    #2;
    check("to_sticky", {31'd0, s_mem_err}, 32'd1);
    check("to_state_run", {30'd0, s_state}, 32'd0);
    check("to_f_no_err", {31'd0, f_mem_err}, 32'd0);

    // Asynchronous reset in the middle of MEM_WAIT.
    mem_req = 1'b1;
    cyc();
    cyc();
    #2;
    check("ar_pre_state", {30'd0, s_state}, 32'd2);
    rst_n = 1'b0;
    mem_req = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    check("ar_pc_en", {31'd0, s_pc_en}, 32'd0);
    check("ar_id_ex_en", {31'd0, s_id_ex_en}, 32'd0);
    check("ar_flush", {31'd0, s_flush}, 32'd0);
    check("ar_state", {30'd0, s_state}, 32'd0);
    check("ar_mem_err", {31'd0, s_mem_err}, 32'd0);
    check("ar_stall", s_stall, 32'd0);
    check("ar_flushes", f_flushes, 32'd0);
    #10;
    idle();
    rst_n = 1'b1;
    cyc();
    #2;
    check("post_state", {30'd0, s_state}, 32'd0);
    check("post_pc_en", {31'd0, s_pc_en}, 32'd1);
    check("post_stall", s_stall, 32'd0);
    check("post_mem_err", {31'd0, s_mem_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
